// File: rtl/booth_share_ctrl.sv
// Round-robin sharing of one start/busy multiplier among N_REQ requesters; one op in flight, resp 3 cycles + busy time after accept.
// Backpressure: a held response blocks new grants and multiplier starts; requests are only granted in IDLE with mul_busy low.
module booth_share_ctrl #(
    parameter int N_REQ    = 4,
    parameter int OP_W     = 8,
    parameter int WAIT_MAX = 4,
    parameter int RUN_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_m,
    input  logic [N_REQ*OP_W-1:0] req_r,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [2*OP_W-1:0]     resp_product,
    output logic                  resp_err,
    output logic                  mul_start,
    output logic [OP_W-1:0]       mul_m,
    output logic [OP_W-1:0]       mul_r,
    input  logic                  mul_busy,
    input  logic [2*OP_W-1:0]     mul_product
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_MAX = (RUN_MAX > WAIT_MAX) ? RUN_MAX : WAIT_MAX;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_RUN, S_ERR, S_RESP
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     grant_q;
    logic [WD_W-1:0]      wdog_q;
    logic [OP_W-1:0]      mul_m_q;
    logic [OP_W-1:0]      mul_r_q;
    logic                 mul_start_q;
    logic [N_REQ-1:0]     resp_valid_q;
    logic                 resp_err_q;
    logic [2*OP_W-1:0]    resp_product_q;

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       cand;
    logic [IDX_W-1:0]     ptr_d;
    logic [OP_W-1:0]      win_m;
    logic [OP_W-1:0]      win_r;
    logic                 accept;

    // First valid requester at or after ptr_q, wrapping at N_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!win_vld && req_valid[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    // The busy guard keeps a multiplier left running by an earlier reset from being restarted.
    assign req_ready = (rst_n && state_q == S_IDLE && !mul_busy && win_vld) ? (ONE << win_idx) : '0;
    assign accept    = |req_ready;
    assign ptr_d     = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_m     = req_m[win_idx*OP_W +: OP_W];
    assign win_r     = req_r[win_idx*OP_W +: OP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            grant_q        <= '0;
            wdog_q         <= '0;
            mul_m_q        <= '0;
            mul_r_q        <= '0;
            mul_start_q    <= 1'b0;
            resp_valid_q   <= '0;
            resp_err_q     <= 1'b0;
            resp_product_q <= '0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_q     <= win_idx;
                        ptr_q       <= ptr_d;
                        mul_m_q     <= win_m;
                        mul_r_q     <= win_r;
                        mul_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (mul_busy) begin
                        wdog_q  <= '0;
                        state_q <= S_RUN;
                    end else if (wdog_q == WD_W'(WAIT_MAX - 1)) begin
                        state_q <= S_ERR;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!mul_busy) begin
                        resp_product_q <= mul_product;
                        resp_err_q     <= 1'b0;
                        resp_valid_q   <= ONE << grant_q;
                        state_q        <= S_RESP;
                    end else if (wdog_q == WD_W'(RUN_MAX - 1)) begin
                        state_q <= S_ERR;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_ERR: begin
                    resp_product_q <= '0;
                    resp_err_q     <= 1'b1;
                    resp_valid_q   <= ONE << grant_q;
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[grant_q]) begin
                        resp_valid_q <= '0;
                        resp_err_q   <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mul_start    = mul_start_q;
    assign mul_m        = mul_m_q;
    assign mul_r        = mul_r_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_product = resp_product_q;

endmodule

// File: doc/booth_share_ctrl.md
Name: booth_share_ctrl

Overview:
- Round-robin controller that shares one Booth multiplier (8x8 -> 16, start/busy interface) among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, sequences the multiplier's start/busy handshake, and returns each product to the requester that issued it.
- Includes a watchdog that returns an error flag when the multiplier fails to respond.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OP_W, 8, operand width; product width is 2*OP_W.
- WAIT_MAX, 4, cycles allowed after mul_start for mul_busy to rise.
- RUN_MAX, 16, cycles allowed for mul_busy to fall once high.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_ready  out  N_REQ  one-hot accept; at most one bit high
- req_m  in  N_REQ*OP_W  multiplicands, packed; requester i at [i*OP_W +: OP_W]
- req_r  in  N_REQ*OP_W  multipliers, packed, same layout as req_m
- resp_valid  out  N_REQ  one-hot response valid
- resp_ready  in  N_REQ  response accept
- resp_product  out  2*OP_W  product for the requester flagged in resp_valid
- resp_err  out  1  response is a watchdog error; product forced to 0
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_m  out  OP_W  multiplicand to multiplier
- mul_r  out  OP_W  multiplier operand to multiplier
- mul_busy  in  1  multiplier busy
- mul_product  in  2*OP_W  multiplier result; valid once busy falls

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - State IDLE; rr pointer = 0; watchdog counter = 0.
- States:
  - IDLE: req_ready[g]=1 combinationally for the winner g, chosen as the first valid requester searching from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). No valid requester: req_ready=0.
    - On req_valid[g]&req_ready[g]: latch g, latch operands into mul_m/mul_r, set ptr = (g+1) mod N_REQ, go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; clear watchdog; go to WAIT_BUSY.
  - WAIT_BUSY: mul_busy=1 -> RUN (clear watchdog). Watchdog reaches WAIT_MAX with busy still 0 -> ERR.
  - RUN: mul_busy=0 -> capture mul_product into resp_product, go to RESP. Watchdog reaches RUN_MAX -> ERR.
  - ERR: resp_product=0, resp_err=1; go to RESP.
  - RESP: resp_valid[g]=1 until resp_ready[g]=1, then clear resp_valid/resp_err and go to IDLE. resp_ready on other bits is ignored.
- mul_m and mul_r stay stable from ISSUE through RUN.
- The multiplier is never started while mul_busy=1. If IDLE sees mul_busy=1 (e.g. after a controller-only reset), req_ready is held 0 until busy falls.
- Throughput: one operation in flight. Best-case latency from acceptance edge to resp_valid = 3 cycles + multiplier busy duration.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows resp handshake completion.
- req_valid may drop without a handshake; it is only sampled in IDLE.
- The captured product is not altered after capture even if mul_product changes.
- Reset mid-operation: returns to IDLE at once and drops any pending response. The multiplier is not reset by this block; the IDLE busy guard covers it.
- Operands are passed through unmodified; signedness is defined by the multiplier.
- No combinational path from resp_ready to req_ready.

Test Plan:
- Single request: requester 1, m=7, r=3; bench multiplier asserts busy for 8 cycles -> one mul_start pulse; resp_valid=4'b0010, resp_product=16'd21, resp_err=0.
- Round robin: requesters 0, 2 and 3 valid continuously with resp_ready tied high -> grant order 0, 2, 3, 0, 2 with no requester starved. Each response matches its own operands (0: 5x5=25; 2: 12x10=120; 3: 255x2=510).
- Response backpressure: resp_ready held low 10 cycles -> resp_valid and resp_product stable; no req_ready asserted; no new mul_start.
- Busy never rises: bench ignores start -> ERR after WAIT_MAX=4 cycles; resp_err=1, resp_product=0; next request is served normally.
- Busy stuck high: after start, busy stays 1 -> error response after RUN_MAX=16 cycles. Following request waits with req_ready=0 until busy falls, then proceeds.
- Reset mid-RUN: rst_n pulsed low -> all outputs 0 immediately. No resp_valid for the aborted operation; the next request is accepted only after mul_busy=0.
